spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Single-chip-select SPI master, mode 0 (SCK idle low).
- Turns one parallel request into one framed serial transaction: drives sck, ss_n and mosi, and samples miso.
- Sits directly upstream of the team's SPI slave peripherals (e.g. the bit-reverse test slave) and feeds their sck/ss/mosi pins.
- Upstream side is a valid/ready request channel from a bus bridge; results return on a valid/ready response channel.

Parameters:
- WIDTH, 16, maximum frame length in bits; width of tx_data/rx_data.
- DIV, 4, SCK half-period in clk cycles; must be >= 1.
- LEN_W, $clog2(WIDTH)+1, width of req_len.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- req_valid  input  1  request present
- req_ready  output  1  master idle, request accepted when valid&ready
- req_data  input  WIDTH  transmit data, MSB-first from bit len-1
- req_len  input  LEN_W  frame length in bits
- rsp_valid  output  1  received data available
- rsp_ready  input  1  response consumed when valid&ready
- rsp_data  output  WIDTH  received bits, right-aligned, upper bits zero
- sck  output  1  SPI clock
- ss_n  output  1  chip select, active-low
- mosi  output  1  serial data out
- miso  input  1  serial data in

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values: sck=0, ss_n=1, mosi=1, req_ready=1, rsp_valid=0, rsp_data=0, state=IDLE.
- Reset mid-transaction: all of the above take effect on the next clk edge; the frame is abandoned and no response is produced.
- Length rule: effective length L = req_len, except:
  - req_len==0 gives L=WIDTH;
  - req_len>WIDTH saturates to WIDTH.
  - L is latched at accept.
- States: IDLE, SETUP, HIGH, LOW, HOLD, RESP. A half-period counter counts DIV cycles in every state except IDLE and RESP.
- IDLE:
  - req_ready=1.
  - On accept: latch data and L; bit_cnt=L-1; on the next edge ss_n=0, mosi=req_data[L-1], sck=0; go to SETUP.
- SETUP: after DIV cycles, sck=1, go to HIGH. The slave samples mosi on this rising edge.
- HIGH: after DIV cycles, sck=0 and shift miso into rx LSB (master samples on the falling edge).
  - If bit_cnt==0: go to HOLD; mosi=1.
  - Else: bit_cnt-=1; mosi=next tx bit; go to LOW.
- LOW: after DIV cycles, sck=1, go to HIGH.
- HOLD: sck stays 0 for DIV cycles, then on the same edge ss_n=1, rsp_valid=1, rsp_data=rx; go to RESP.
- RESP:
  - rsp_valid and rsp_data hold stable until rsp_ready.
  - On the handshake edge: rsp_valid=0, go to IDLE.
  - req_ready=0 in RESP; no overlapping frames.
- Timing:
  - ss_n is low for exactly (2L+2)*DIV clk cycles.
  - sck shows exactly L rising edges per frame.
  - mosi changes only while sck=0 (or at the ss_n edges).
- req_ready is 0 in every state except IDLE. req_valid asserted while busy is ignored, not lost; the upstream holds it.
- rsp_data bit i = miso sampled at falling edge number (L-i), counting the first falling edge as 1. Bits >= L are 0.
- Back-to-back frames: the earliest next accept is the cycle after the response handshake. ss_n is high for at least 1 clk between frames.

Decomposition:
- Shared package spi_pkg:
  - state enum (IDLE, SETUP, HIGH, LOW, HOLD, RESP);
  - SPI_IDLE_MOSI=1'b1;
  - default DIV and WIDTH constants.
- One natural sub-module: spi_clkgen. It is the half-period counter with a tick output, loaded on state entry.
- The shift registers and FSM stay in spi_master.

Test Plan:
- Loopback (miso=mosi), req_data=16'hA5C3, len=16, DIV=4 -> rsp_data=16'hA5C3; 16 sck rising edges; ss_n low exactly 136 cycles.
- Slave model drives miso=1 throughout, len=5 -> rsp_data=16'h001F; mosi returns to 1 before ss_n rises.
- req_len=0 and req_len=31, loopback, req_data=16'h8001 -> both frames have 16 bits; rsp_data=16'h8001.
- Hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid/rsp_data stable; req_ready=0; a second req_valid is not accepted until 1 cycle after the handshake.
- Drop rst_n for 1 cycle after the 3rd rising sck edge -> next cycle sck=0, ss_n=1, mosi=1, rsp_valid=0, req_ready=1; no response is ever issued.
- DIV=1, loopback, len=1, req_data bit0=0 -> rsp_data=0; ss_n low exactly 4 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM states, idle line level,
// default geometry and the frame-length saturation rule.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        RESP
    } state_t;

    localparam logic        SPI_IDLE_MOSI = 1'b1;
    localparam int unsigned SPI_DEF_DIV   = 4;
    localparam int unsigned SPI_DEF_WIDTH = 16;

    // Zero selects a full-width frame; anything above the width saturates.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Request/response channel between the bus bridge and the SPI master.
// The bridge uses the master modport, the SPI master uses the slave modport.
interface spi_master_if
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_DEF_WIDTH,
    parameter int unsigned LEN_W = $clog2(WIDTH) + 1
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [LEN_W-1:0] req_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid, req_data, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_data, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/spi_clkgen.sv
// SCK half-period timer: counts DIV clk cycles while running and pulses
// tick_c on the last cycle of each half-period; load restarts the count.
module spi_clkgen
    import spi_pkg::*;
#(
    parameter int unsigned DIV = SPI_DEF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick_c = run && (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: turns one accepted request into one ss_n-framed
// transfer (MSB first) and returns the sampled miso bits as a response.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_DEF_WIDTH,
    parameter int unsigned DIV   = SPI_DEF_DIV,
    parameter int unsigned LEN_W = $clog2(WIDTH) + 1
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.slave bus,
    output logic        sck,
    output logic        ss_n,
    output logic        mosi,
    input  logic        miso
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             hold_q, hold_d;
    logic             sck_d, ss_n_d, mosi_d;
    logic             req_ready_d, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_d;

    logic             accept;
    logic             run;
    logic             tick_c;
    logic [LEN_W-1:0] len_eff;
    logic             first_bit;
    logic             next_bit;

    assign accept    = bus.req_valid && bus.req_ready;
    assign run       = (state_q != IDLE) && (state_q != RESP);
    assign len_eff   = LEN_W'(eff_len(32'(bus.req_len), WIDTH));
    assign first_bit = |(bus.req_data & (WIDTH'(1) << (len_eff - LEN_W'(1))));
    assign next_bit  = |(tx_q & (WIDTH'(1) << (bit_cnt_q - LEN_W'(1))));

    spi_clkgen #(.DIV(DIV)) u_clkgen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .run    (run),
        .tick_c (tick_c)
    );

    // Next-state and next-output logic; every register holds unless a tick moves it.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        sck_d       = sck;
        ss_n_d      = ss_n;
        mosi_d      = mosi;
        rsp_valid_d = bus.rsp_valid;
        rsp_data_d  = bus.rsp_data;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_d      = bus.req_data;
                    rx_d      = '0;
                    bit_cnt_d = len_eff - LEN_W'(1);
                    hold_d    = 1'b0;
                    ss_n_d    = 1'b0;
                    sck_d     = 1'b0;
                    mosi_d    = first_bit;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick_c) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (tick_c) begin
                    sck_d = 1'b0;
                    rx_d  = (rx_q << 1) | WIDTH'(miso);
                    if (bit_cnt_q == '0) begin
                        mosi_d  = SPI_IDLE_MOSI;
                        hold_d  = 1'b0;
                        state_d = HOLD;
                    end else begin
                        bit_cnt_d = bit_cnt_q - LEN_W'(1);
                        mosi_d    = next_bit;
                        state_d   = LOW;
                    end
                end
            end
            LOW: begin
                if (tick_c) begin
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end
            end
            // The last sck-low half-period plus one hold half-period,
            // giving ss_n low for (2L+2)*DIV cycles.
            HOLD: begin
                if (tick_c) begin
                    if (!hold_q) begin
                        hold_d = 1'b1;
                    end else begin
                        ss_n_d      = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = rx_q;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_q          <= '0;
            rx_q          <= '0;
            bit_cnt_q     <= '0;
            hold_q        <= 1'b0;
            sck           <= 1'b0;
            ss_n          <= 1'b1;
            mosi          <= SPI_IDLE_MOSI;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            state_q       <= state_d;
            tx_q          <= tx_d;
            rx_q          <= rx_d;
            bit_cnt_q     <= bit_cnt_d;
            hold_q        <= hold_d;
            sck           <= sck_d;
            ss_n          <= ss_n_d;
            mosi          <= mosi_d;
            bus.req_ready <= req_ready_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_data  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a DIV=4 and a DIV=1 instance, a pin monitor, a simple
// mode-0 slave and a length/mask reference model.
module tb_spi_master;

    localparam int unsigned W  = 16;
    localparam int unsigned LW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_if #(.WIDTH(W), .LEN_W(LW)) bus4 ();
    spi_master_if #(.WIDTH(W), .LEN_W(LW)) bus1 ();

    logic sck4, ss4, mosi4, miso4;
    logic sck1, ss1, mosi1, miso1;
    logic        loop_en  = 1'b1;
    logic [31:0] slv_bits = '0;
    logic [4:0]  slv_idx  = '0;

    assign miso4 = loop_en ? mosi4 : slv_bits[slv_idx];
    assign miso1 = mosi1;

    spi_master #(.WIDTH(W), .DIV(4), .LEN_W(LW)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4),
        .sck(sck4), .ss_n(ss4), .mosi(mosi4), .miso(miso4)
    );

    spi_master #(.WIDTH(W), .DIV(1), .LEN_W(LW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .sck(sck1), .ss_n(ss1), .mosi(mosi1), .miso(miso1)
    );

    int tests = 0;
    int fails = 0;

    // Pin monitor: frame length, sck rising edges, mosi seen at rising edges.
    logic [1:0]  sck_v, ss_v, mosi_v;
    logic [1:0]  sck_p = 2'b00, ss_p = 2'b11, mosi_p = 2'b11;
    int          ss_low_cnt[2], last_ss_low[2], rise_cnt[2], last_rises[2], mosi_viol[2];
    logic [1:0]  mosi_pre_rise = 2'b00;
    logic [15:0] mosi_seen     = '0;

    assign sck_v  = {sck1, sck4};
    assign ss_v   = {ss1, ss4};
    assign mosi_v = {mosi1, mosi4};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ss_p[i] && !ss_v[i]) begin
                ss_low_cnt[i] = 0;
                rise_cnt[i]   = 0;
                if (i == 0) begin
                    mosi_seen = '0;
                    slv_idx   = '0;
                end
            end
            if (!ss_v[i]) ss_low_cnt[i]++;
            if (!ss_p[i] && ss_v[i]) begin
                last_ss_low[i]   = ss_low_cnt[i];
                last_rises[i]    = rise_cnt[i];
                mosi_pre_rise[i] = mosi_p[i];
            end
            if (sck_v[i] && !sck_p[i]) begin
                rise_cnt[i]++;
                if (i == 0) mosi_seen = {mosi_seen[14:0], mosi_v[0]};
            end
            if (!sck_v[i] && sck_p[i] && (i == 0)) slv_idx = slv_idx + 5'd1;
            if ((mosi_v[i] !== mosi_p[i]) && sck_v[i] && (ss_v[i] == ss_p[i])) mosi_viol[i]++;
        end
        sck_p  = sck_v;
        ss_p   = ss_v;
        mosi_p = mosi_v;
    end

    // Reference model: saturated length and right-aligned expected data.
    function automatic int unsigned model_len(input logic [4:0] len);
        return ((len == 5'd0) || (32'(len) > W)) ? W : 32'(len);
    endfunction

    function automatic logic [15:0] model_mask(input logic [15:0] data, input int unsigned l);
        logic [31:0] m;
        m = (32'd1 << l) - 32'd1;
        return data & m[15:0];
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? bus4.req_ready : bus1.req_ready;
    endfunction

    function automatic logic rval(input int d);
        return (d == 0) ? bus4.rsp_valid : bus1.rsp_valid;
    endfunction

    function automatic logic [15:0] rdat(input int d);
        return (d == 0) ? bus4.rsp_data : bus1.rsp_data;
    endfunction

    task automatic set_req(input int d, input logic v, input logic [15:0] data, input logic [4:0] len);
        if (d == 0) begin
            bus4.req_valid = v; bus4.req_data = data; bus4.req_len = len;
        end else begin
            bus1.req_valid = v; bus1.req_data = data; bus1.req_len = len;
        end
    endtask

    task automatic set_rready(input int d, input logic v);
        if (d == 0) bus4.rsp_ready = v;
        else        bus1.rsp_ready = v;
    endtask

    task automatic wait_accept(input int d);
        int n = 0;
        while (!rdy(d) && n < 2000) begin @(negedge clk); #1; n++; end
        @(negedge clk); #1;
    endtask

    task automatic wait_rsp(input int d, output bit to);
        int n = 0;
        while (!rval(d) && n < 4000) begin @(negedge clk); #1; n++; end
        to = !rval(d);
    endtask

    task automatic run_frame(input int d, input logic [15:0] data, input logic [4:0] len,
                             output logic [15:0] rsp, output bit to);
        set_req(d, 1'b1, data, len);
        wait_accept(d);
        set_req(d, 1'b0, '0, '0);
        wait_rsp(d, to);
        rsp = rdat(d);
        set_rready(d, 1'b1);
        @(negedge clk); #1;
        set_rready(d, 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({sck4, ss4, mosi4, bus4.req_ready, bus4.rsp_valid} !== 5'b01110) begin
            fails++;
            $display("FAIL reset_pins4: got %b want 01110", {sck4, ss4, mosi4, bus4.req_ready, bus4.rsp_valid});
        end
        tests++;
        if (bus4.rsp_data !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rsp_data: got %h want 0000", bus4.rsp_data);
        end
        tests++;
        if ({sck1, ss1, mosi1, bus1.req_ready, bus1.rsp_valid} !== 5'b01110) begin
            fails++;
            $display("FAIL reset_pins1: got %b want 01110", {sck1, ss1, mosi1, bus1.req_ready, bus1.rsp_valid});
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic check_frame4(input string tag, input logic [15:0] data, input logic [4:0] len,
                                input logic [15:0] want, input logic [15:0] got, input bit to);
        int unsigned l;
        l = model_len(len);
        tests++;
        if (to || (got !== want)) begin
            fails++;
            $display("FAIL %s rsp_data: got %h want %h (timeout=%0d)", tag, got, want, to);
        end
        tests++;
        if (last_rises[0] != int'(l)) begin
            fails++;
            $display("FAIL %s sck_rises: got %0d want %0d", tag, last_rises[0], l);
        end
        tests++;
        if (last_ss_low[0] != int'((2 * l + 2) * 4)) begin
            fails++;
            $display("FAIL %s ss_low_cycles: got %0d want %0d", tag, last_ss_low[0], (2 * l + 2) * 4);
        end
        tests++;
        if (mosi_seen !== model_mask(data, l)) begin
            fails++;
            $display("FAIL %s mosi_bits: got %h want %h", tag, mosi_seen, model_mask(data, l));
        end
    endtask

    task automatic test_loopback();
        logic [15:0] data, got;
        logic [4:0]  len;
        bit          to;
        loop_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            data = (k == 0) ? 16'hA5C3 : 16'($urandom);
            len  = (k == 0) ? 5'd16 : 5'($urandom_range(0, 31));
            run_frame(0, data, len, got, to);
            check_frame4("loopback", data, len, model_mask(data, model_len(len)), got, to);
        end
        tests++;
        if (mosi_viol[0] != 0) begin
            fails++;
            $display("FAIL mosi_while_sck_high: got %0d changes want 0", mosi_viol[0]);
        end
    endtask

    task automatic test_slave();
        logic [15:0] data, got, want;
        logic [4:0]  len;
        bit          to;
        int unsigned l;
        loop_en  = 1'b0;
        slv_bits = '1;
        data     = 16'($urandom);
        run_frame(0, data, 5'd5, got, to);
        check_frame4("miso_ones", data, 5'd5, 16'h001F, got, to);
        tests++;
        if (mosi_pre_rise[0] !== 1'b1) begin
            fails++;
            $display("FAIL mosi_idle_before_ss: got %b want 1", mosi_pre_rise[0]);
        end
        for (int k = 0; k < 6; k++) begin
            slv_bits = $urandom;
            data     = 16'($urandom);
            len      = 5'($urandom_range(0, 31));
            l        = model_len(len);
            want     = '0;
            for (int b = 0; b < int'(l); b++) want[int'(l) - 1 - b] = slv_bits[b];
            run_frame(0, data, len, got, to);
            check_frame4("slave_rand", data, len, want, got, to);
        end
        loop_en = 1'b1;
    endtask

    task automatic test_len_saturate();
        logic [15:0] got;
        bit          to;
        run_frame(0, 16'h8001, 5'd0, got, to);
        check_frame4("len0", 16'h8001, 5'd0, 16'h8001, got, to);
        run_frame(0, 16'h8001, 5'd31, got, to);
        check_frame4("len31", 16'h8001, 5'd31, 16'h8001, got, to);
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1, d2, got;
        logic [4:0]  len2;
        bit          to;
        d1   = 16'($urandom);
        d2   = 16'($urandom);
        len2 = 5'($urandom_range(1, 16));
        set_req(0, 1'b1, d1, 5'd16);
        wait_accept(0);
        set_req(0, 1'b1, d2, len2);
        wait_rsp(0, to);
        for (int c = 0; c < 20; c++) begin
            tests++;
            if (to || ({bus4.rsp_valid, bus4.req_ready, ss4, bus4.rsp_data} !== {3'b101, d1})) begin
                fails++;
                $display("FAIL stall_cycle%0d: got v=%b rdy=%b ss_n=%b data=%h want v=1 rdy=0 ss_n=1 data=%h",
                         c, bus4.rsp_valid, bus4.req_ready, ss4, bus4.rsp_data, d1);
            end
            @(negedge clk); #1;
        end
        set_rready(0, 1'b1);
        @(negedge clk); #1;
        set_rready(0, 1'b0);
        tests++;
        if ({bus4.rsp_valid, bus4.req_ready, ss4} !== 3'b011) begin
            fails++;
            $display("FAIL after_handshake: got v/rdy/ss_n=%b want 011", {bus4.rsp_valid, bus4.req_ready, ss4});
        end
        @(negedge clk); #1;
        set_req(0, 1'b0, '0, '0);
        tests++;
        if ({bus4.req_ready, ss4} !== 2'b00) begin
            fails++;
            $display("FAIL second_accept: got rdy/ss_n=%b want 00", {bus4.req_ready, ss4});
        end
        wait_rsp(0, to);
        got = bus4.rsp_data;
        set_rready(0, 1'b1);
        @(negedge clk); #1;
        set_rready(0, 1'b0);
        check_frame4("second_frame", d2, len2, model_mask(d2, model_len(len2)), got, to);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int rsp_seen = 0;
        int ss_seen  = 0;
        set_req(0, 1'b1, 16'($urandom), 5'd16);
        wait_accept(0);
        set_req(0, 1'b0, '0, '0);
        while (rise_cnt[0] < 3 && n < 2000) begin @(negedge clk); #1; n++; end
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if ({sck4, ss4, mosi4, bus4.rsp_valid, bus4.req_ready} !== 5'b01101) begin
            fails++;
            $display("FAIL reset_mid_pins: got sck/ss_n/mosi/v/rdy=%b want 01101",
                     {sck4, ss4, mosi4, bus4.rsp_valid, bus4.req_ready});
        end
        repeat (200) begin
            @(negedge clk); #1;
            if (bus4.rsp_valid) rsp_seen++;
            if (!ss4) ss_seen++;
        end
        tests++;
        if ((rsp_seen != 0) || (ss_seen != 0)) begin
            fails++;
            $display("FAIL reset_mid_no_rsp: got rsp_cycles=%0d ss_low_cycles=%0d want 0 0", rsp_seen, ss_seen);
        end
    endtask

    task automatic test_div1();
        logic [15:0] data, got;
        logic [4:0]  len;
        bit          to;
        int unsigned l;
        for (int k = 0; k < 6; k++) begin
            data = 16'($urandom);
            len  = 5'($urandom_range(0, 31));
            if (k == 0) begin data[0] = 1'b0; len = 5'd1; end
            if (k == 1) begin data[0] = 1'b1; len = 5'd1; end
            l = model_len(len);
            run_frame(1, data, len, got, to);
            tests++;
            if (to || (got !== model_mask(data, l))) begin
                fails++;
                $display("FAIL div1_rsp%0d: got %h want %h (timeout=%0d)", k, got, model_mask(data, l), to);
            end
            tests++;
            if ((last_ss_low[1] != int'(2 * l + 2)) || (last_rises[1] != int'(l))) begin
                fails++;
                $display("FAIL div1_timing%0d: got ss_low=%0d rises=%0d want %0d %0d",
                         k, last_ss_low[1], last_rises[1], 2 * l + 2, l);
            end
        end
        tests++;
        if (mosi_viol[1] != 0) begin
            fails++;
            $display("FAIL div1_mosi_while_sck_high: got %0d want 0", mosi_viol[1]);
        end
    endtask

    initial begin
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        set_rready(0, 1'b0);
        set_rready(1, 1'b0);
        test_reset();
        test_loopback();
        test_slave();
        test_len_saturate();
        test_back_to_back();
        test_reset_mid();
        test_div1();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
